// File: rtl/rx_lane_sync_ctrl.sv
// Two-lane receive link bring-up: per-lane comma lock, lane-to-lane
// slot alignment check, and comma-stripped forwarding to the packers.
module rx_lane_sync_ctrl #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] data_in0,
    input  logic       valid_in0,
    input  logic [7:0] data_in1,
    input  logic       valid_in1,
    output logic [1:0] lock,
    output logic       active,
    output logic       skew_err,
    output logic [7:0] data_out0,
    output logic       valid_out0,
    output logic [7:0] data_out1,
    output logic       valid_out1
);

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);
    localparam logic [3:0] LOSS_LAST = 4'(LOSS_COUNT - 1);

    typedef enum logic {
        L_HUNT,
        L_LOCKED
    } lane_t;

    typedef enum logic [1:0] {
        G_WAIT,
        G_ALIGN,
        G_ACTIVE
    } glob_t;

    logic [7:0] din   [2];
    logic       vin   [2];
    logic       dv    [2];
    lane_t      lane_q[2];
    lane_t      lane_d[2];
    logic [3:0] cnt_q [2];
    logic [3:0] cnt_d [2];
    logic [3:0] err_q [2];
    logic [3:0] err_d [2];
    logic [1:0] lock_nxt;
    logic       drop;
    glob_t      g_q;
    glob_t      g_d;
    logic       fwd;
    logic       skew_set;

    assign din[0] = data_in0;
    assign din[1] = data_in1;
    assign vin[0] = valid_in0;
    assign vin[1] = valid_in1;
    assign dv[0]  = valid_in0 && (data_in0 != COMMA);
    assign dv[1]  = valid_in1 && (data_in1 != COMMA);

    // Lane FSMs: state register
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 2; n++) begin
                lane_q[n] <= L_HUNT;
                cnt_q[n]  <= '0;
                err_q[n]  <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                lane_q[n] <= lane_d[n];
                cnt_q[n]  <= cnt_d[n];
                err_q[n]  <= err_d[n];
            end
        end
    end

    // Lane FSMs: next state
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            lane_d[n] = lane_q[n];
            cnt_d[n]  = cnt_q[n];
            err_d[n]  = err_q[n];
            unique case (lane_q[n])
                L_HUNT: begin
                    if (vin[n] && din[n] == COMMA) begin
                        if (cnt_q[n] == LOCK_LAST) begin
                            lane_d[n] = L_LOCKED;
                            cnt_d[n]  = '0;
                            err_d[n]  = '0;
                        end else begin
                            cnt_d[n] = cnt_q[n] + 4'd1;
                        end
                    end else if (vin[n]) begin
                        cnt_d[n] = '0;
                    end
                end
                L_LOCKED: begin
                    if (!vin[n]) begin
                        if (err_q[n] == LOSS_LAST) begin
                            lane_d[n] = L_HUNT;
                            cnt_d[n]  = '0;
                            err_d[n]  = '0;
                        end else begin
                            err_d[n] = err_q[n] + 4'd1;
                        end
                    end else begin
                        err_d[n] = '0;
                    end
                end
            endcase
        end
    end

    // Lane FSMs: outputs
    always_comb begin
        lock     = '0;
        lock_nxt = '0;
        for (int n = 0; n < 2; n++) begin
            lock[n]     = (lane_q[n] == L_LOCKED);
            lock_nxt[n] = (lane_d[n] == L_LOCKED);
        end
    end

    // A lock lost on this edge must win over any alignment decision
    assign drop = !(&lock_nxt);

    // Global FSM: state register
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            g_q <= G_WAIT;
        end else begin
            g_q <= g_d;
        end
    end

    // Global FSM: next state
    always_comb begin
        g_d = g_q;
        unique case (g_q)
            G_WAIT: begin
                if (&lock) begin
                    g_d = G_ALIGN;
                end
            end
            G_ALIGN: begin
                if (drop) begin
                    g_d = G_WAIT;
                end else if (dv[0] && dv[1]) begin
                    g_d = G_ACTIVE;
                end else if (dv[0] != dv[1]) begin
                    g_d = G_WAIT;
                end
            end
            G_ACTIVE: begin
                if (drop) begin
                    g_d = G_WAIT;
                end
            end
            default: g_d = G_WAIT;
        endcase
    end

    // Global FSM: outputs
    always_comb begin
        fwd      = 1'b0;
        skew_set = 1'b0;
        unique case (g_q)
            G_ALIGN: begin
                fwd      = !drop && dv[0] && dv[1];
                skew_set = !drop && (dv[0] != dv[1]);
            end
            G_ACTIVE: begin
                fwd = !drop;
            end
            default: begin
                fwd      = 1'b0;
                skew_set = 1'b0;
            end
        endcase
    end

    assign active = (g_q == G_ACTIVE);

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            data_out0  <= '0;
            data_out1  <= '0;
            valid_out0 <= 1'b0;
            valid_out1 <= 1'b0;
            skew_err   <= 1'b0;
        end else begin
            data_out0  <= data_in0;
            data_out1  <= data_in1;
            valid_out0 <= fwd && dv[0];
            valid_out1 <= fwd && dv[1];
            skew_err   <= skew_set;
        end
    end

endmodule

// File: tb/tb_rx_lane_sync_ctrl.sv
// Bench for rx_lane_sync_ctrl: directed bring-up scenarios followed by
// randomized traffic, all checked against a behavioural link model.
module tb_rx_lane_sync_ctrl;

    logic       clk_4f = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] data_in0  = '0;
    logic       valid_in0 = 1'b0;
    logic [7:0] data_in1  = '0;
    logic       valid_in1 = 1'b0;
    logic [1:0] lock;
    logic       active;
    logic       skew_err;
    logic [7:0] data_out0;
    logic       valid_out0;
    logic [7:0] data_out1;
    logic       valid_out1;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the link
    bit         m_lock [2];
    int         m_run  [2];
    int         m_miss [2];
    int         m_mode;
    logic [7:0] e_dout [2];
    bit         e_vout [2];
    bit         e_skew;
    bit         e_active;

    rx_lane_sync_ctrl dut (
        .clk_4f     (clk_4f),
        .reset      (reset),
        .data_in0   (data_in0),
        .valid_in0  (valid_in0),
        .data_in1   (data_in1),
        .valid_in1  (valid_in1),
        .lock       (lock),
        .active     (active),
        .skew_err   (skew_err),
        .data_out0  (data_out0),
        .valid_out0 (valid_out0),
        .data_out1  (data_out1),
        .valid_out1 (valid_out1)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_lock[n] = 0;
            m_run[n]  = 0;
            m_miss[n] = 0;
            e_dout[n] = '0;
            e_vout[n] = 0;
        end
        m_mode   = 0;
        e_skew   = 0;
        e_active = 0;
    endtask

    // mode: 0 waiting for both locks, 1 aligning, 2 forwarding
    task automatic model_step(input bit v0, input logic [7:0] d0,
                              input bit v1, input logic [7:0] d1);
        bit         v  [2];
        logic [7:0] d  [2];
        bit         dv [2];
        bit         nl [2];
        bit         drop;
        bit         fwd;
        v[0] = v0; v[1] = v1;
        d[0] = d0; d[1] = d1;
        for (int n = 0; n < 2; n++) begin
            dv[n] = v[n] && (d[n] != 8'hBC);
            nl[n] = m_lock[n];
            if (!m_lock[n]) begin
                if (v[n] && d[n] == 8'hBC) begin
                    m_run[n]++;
                    if (m_run[n] == 4) begin
                        nl[n] = 1; m_run[n] = 0; m_miss[n] = 0;
                    end
                end else if (v[n]) begin
                    m_run[n] = 0;
                end
            end else if (!v[n]) begin
                m_miss[n]++;
                if (m_miss[n] == 3) begin
                    nl[n] = 0; m_run[n] = 0; m_miss[n] = 0;
                end
            end else begin
                m_miss[n] = 0;
            end
        end
        drop   = !(nl[0] && nl[1]);
        fwd    = 0;
        e_skew = 0;
        case (m_mode)
            0: if (m_lock[0] && m_lock[1]) m_mode = 1;
            1: begin
                if (drop) m_mode = 0;
                else if (dv[0] && dv[1]) begin m_mode = 2; fwd = 1; end
                else if (dv[0] != dv[1]) begin m_mode = 0; e_skew = 1; end
            end
            default: begin
                if (drop) m_mode = 0;
                else fwd = 1;
            end
        endcase
        for (int n = 0; n < 2; n++) begin
            m_lock[n] = nl[n];
            e_vout[n] = fwd && dv[n];
            e_dout[n] = d[n];
        end
        e_active = (m_mode == 2);
    endtask

    task automatic check_all();
        chk("lock",       {6'b0, lock},       {6'b0, m_lock[1], m_lock[0]});
        chk("active",     {7'b0, active},     {7'b0, e_active});
        chk("skew_err",   {7'b0, skew_err},   {7'b0, e_skew});
        chk("data_out0",  data_out0,          e_dout[0]);
        chk("data_out1",  data_out1,          e_dout[1]);
        chk("valid_out0", {7'b0, valid_out0}, {7'b0, e_vout[0]});
        chk("valid_out1", {7'b0, valid_out1}, {7'b0, e_vout[1]});
    endtask

    // One byte slot: drive between edges, clock it, then compare
    task automatic cyc(input bit v0, input logic [7:0] d0,
                       input bit v1, input logic [7:0] d1);
        valid_in0 = v0; data_in0 = d0;
        valid_in1 = v1; data_in1 = d1;
        @(posedge clk_4f);
        model_step(v0, d0, v1, d1);
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rst_lock",   {6'b0, lock},       8'h00);
        chk("rst_active", {7'b0, active},     8'h00);
        chk("rst_skew",   {7'b0, skew_err},   8'h00);
        chk("rst_vout0",  {7'b0, valid_out0}, 8'h00);
        chk("rst_vout1",  {7'b0, valid_out1}, 8'h00);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] s0 [8];
        model_reset();
        repeat (2) @(posedge clk_4f);
        #1;
        check_all();
        chk("init_dout0", data_out0, 8'h00);
        reset = 1'b0;

        // Bring-up: four commas lock both lanes, then first data pair
        repeat (4) cyc(1, 8'hBC, 1, 8'hBC);
        chk("lock_4commas", {6'b0, lock}, 8'h03);
        cyc(1, 8'hBC, 1, 8'hBC);
        cyc(1, 8'h11, 1, 8'h22);
        chk("first_active", {7'b0, active}, 8'h01);
        chk("first_d0", data_out0, 8'h11);
        chk("first_d1", data_out1, 8'h22);
        chk("first_v", {6'b0, valid_out1, valid_out0}, 8'h03);

        // Comma on lane 1 is idle fill and is stripped
        cyc(1, 8'h33, 1, 8'hBC);
        chk("strip_v0", {7'b0, valid_out0}, 8'h01);
        chk("strip_d0", data_out0, 8'h33);
        chk("strip_v1", {7'b0, valid_out1}, 8'h00);

        // Lane 1 goes quiet for three slots
        repeat (3) cyc(1, 8'h44, 0, 8'h00);
        chk("loss_lock", {6'b0, lock}, 8'h01);
        chk("loss_active", {7'b0, active}, 8'h00);
        chk("loss_v0", {7'b0, valid_out0}, 8'h00);
        repeat (3) cyc(1, 8'hBC, 1, 8'hBC);
        chk("relock3", {6'b0, lock}, 8'h01);
        cyc(1, 8'hBC, 1, 8'hBC);
        chk("relock4", {6'b0, lock}, 8'h03);

        // Skew: data on lane 0 only while aligning
        cyc(1, 8'hBC, 1, 8'hBC);
        cyc(1, 8'hAA, 1, 8'hBC);
        chk("skew_pulse", {7'b0, skew_err}, 8'h01);
        chk("skew_v0", {7'b0, valid_out0}, 8'h00);
        chk("skew_active", {7'b0, active}, 8'h00);
        cyc(1, 8'hBC, 1, 8'hBC);
        chk("skew_clear", {7'b0, skew_err}, 8'h00);
        cyc(1, 8'h01, 1, 8'h02);
        chk("realign", {7'b0, active}, 8'h01);
        cyc(1, 8'h55, 1, 8'h66);

        // Reset mid-operation, then an interrupted comma run on lane 0
        async_reset();
        s0[0] = 8'hBC; s0[1] = 8'hBC; s0[2] = 8'hBC; s0[3] = 8'h05;
        s0[4] = 8'hBC; s0[5] = 8'hBC; s0[6] = 8'hBC; s0[7] = 8'hBC;
        for (int i = 0; i < 8; i++) begin
            cyc(1, s0[i], i < 3, 8'hBC);
            if (i == 6) chk("run_not_yet", {6'b0, lock}, 8'h00);
        end
        chk("run_lock0", {6'b0, lock}, 8'h01);
        cyc(1, 8'hBC, 1, 8'hBC);
        chk("held_cnt_lock", {6'b0, lock}, 8'h03);

        // Randomized traffic with periodic comma bursts
        for (int i = 0; i < 3000; i++) begin
            if (i % 120 < 6) begin
                cyc(1, 8'hBC, 1, 8'hBC);
            end else begin
                cyc($urandom_range(0, 9) != 0,
                    ($urandom_range(0, 9) < 4) ? 8'hBC : 8'($urandom),
                    $urandom_range(0, 9) != 0,
                    ($urandom_range(0, 9) < 4) ? 8'hBC : 8'($urandom));
            end
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_lane_sync_ctrl.md
# rx_lane_sync_ctrl

Link-bring-up controller for the two-lane PHY receiver. It sits between the two serial-to-parallel converters and the 8-to-32-bit packers, and runs in the byte clock domain. It hunts for comma (0xBC) training bytes on each lane, declares per-lane lock, and checks that both lanes leave training in the same byte slot. Once the lanes are aligned, it forwards the data bytes to the packers, so downstream un-striping only ever sees aligned, comma-free data.

## Interface
- COMMA, 8'hBC: training/idle symbol.
- LOCK_COUNT, 4: consecutive valid commas required for lane lock (range 2..15).
- LOSS_COUNT, 3: consecutive invalid byte slots that drop lane lock (range 1..15).
- clk_4f  in  1  byte clock; single clock of the block; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears every register and output to 0.
- data_in0  in  8  lane 0 byte from serial-to-parallel.
- valid_in0  in  1  lane 0 byte valid.
- data_in1  in  8  lane 1 byte.
- valid_in1  in  1  lane 1 byte valid.
- lock  out  2  per-lane lock flags; bit n = lane n.
- active  out  1  link aligned and forwarding.
- skew_err  out  1  one-cycle pulse on alignment failure.
- data_out0  out  8  registered lane 0 byte.
- valid_out0  out  1  lane 0 forwarded byte valid.
- data_out1  out  8  registered lane 1 byte.
- valid_out1  out  1  lane 1 forwarded byte valid.

## Operation
- Each lane has its own FSM with 4-bit counters cnt and err.
- **HUNT:**
  - valid and byte==COMMA: cnt+1.
  - valid and byte!=COMMA: cnt=0.
  - invalid: cnt holds.
  - When the LOCK_COUNT-th consecutive comma is sampled: go to LOCKED, cnt=0, err=0.
- **LOCKED:**
  - Invalid slot: err+1.
  - Valid slot (comma or data): err=0.
  - When err reaches LOSS_COUNT: go to HUNT, cnt=0, and lock bit clears.
- The lane lock bit is 1 exactly while that lane's FSM is in LOCKED.
- **Global FSM, WAIT** (active=0): go to ALIGN when lock==2'b11.
- **Global FSM, ALIGN** (active=0):
  - Both lanes valid with non-comma bytes in the same cycle: go to ACTIVE. This first byte pair is forwarded.
  - Exactly one lane valid with a non-comma byte while the other lane is invalid or carries a comma: pulse skew_err, go to WAIT. That byte is not forwarded.
  - Either lock bit drops: go to WAIT with no skew_err.
- **Global FSM, ACTIVE** (active=1): forward every byte; commas are treated as idle fill and stripped.
  - Either lock bit drops: go to WAIT.
  - A byte sampled in the same cycle the lock drops is not forwarded.
- **Forwarding** (lane n): data_outn <= data_inn on every clock, always registered.
  - valid_outn <= valid_inn and data_inn!=COMMA, qualified by one condition:
    - global state is ACTIVE and stays ACTIVE this cycle, or
    - this is the ALIGN->ACTIVE transition cycle.
  - Otherwise valid_outn <= 0.
- Simultaneous events:
  - Lock loss has priority over alignment/skew decisions.
  - Re-entry from WAIT to ALIGN happens on the next cycle if both lanes are still locked.

## Timing
- lock[n] rises on the clk_4f edge that samples the LOCK_COUNT-th consecutive comma; it is visible the following cycle.
- lock[n] falls on the edge that samples the LOSS_COUNT-th consecutive invalid slot.
- WAIT->ALIGN takes 1 cycle after lock==11 is visible.
- ALIGN->ACTIVE happens on the edge that samples the first aligned data pair. active and valid_out0/1 assert together, on that same edge.
- Forward latency: exactly 1 clk_4f cycle from data_in to data_out, with no bubbles.
- skew_err is high for exactly one cycle, registered, on the edge that detects the skew.
- Reset is asynchronous and can arrive mid-operation. All outputs go to 0 immediately, both lane FSMs return to HUNT with zero counters, and the global FSM returns to WAIT.

## Test plan
- **Lock on both lanes:** after reset, both lanes send 4 valid 0xBC, then 0x11/0x22 together.
  - lock=11 one cycle after the 4th comma.
  - active=1 and data_out0=0x11, data_out1=0x22, valid_out=1/1 one cycle after the data pair.
- **Interrupted comma run:** lane 0 sends BC,BC,BC,0x05,BC,BC,BC,BC. lock[0] rises only after the final BC (8th byte).
- **Skew:** both lanes locked, lane 0 sends 0xAA while lane 1 sends 0xBC.
  - skew_err pulses 1 cycle, valid_out0 stays 0, active=0.
  - Next pair 0x01/0x02 together gives active=1.
- **Stripping in ACTIVE:** lane 1 sends 0xBC mid-stream while lane 0 sends 0x33. Then valid_out0=1 with data_out0=0x33, and valid_out1=0.
- **Lock loss:** in ACTIVE, lane 1 sends 3 invalid slots.
  - lock=01 and active=0 after the 3rd slot; no valid_out from then on.
  - Re-lock needs 4 new commas on lane 1.
- **Mid-operation reset:** assert reset asynchronously between edges during ACTIVE.
  - lock, active, skew_err and valid_out go to 0 immediately.
  - After release, 3 commas do not lock; 4 do.
